// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: NOP encoding, default reset PC and the IF/ID
// bundle that the decode stage also consumes.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        exc;
    } if_id_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: holds on stall; on flush captures a bubble that
// keeps the incoming PC.
module if_id_reg
    import fetch_unit_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   stall,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (!stall) begin
            if (flush) begin
                q_d.instr = NOP_INSTR;
                q_d.pc    = d.pc;
                q_d.valid = 1'b0;
                q_d.exc   = 1'b0;
            end else begin
                q_d = d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, next-PC selection, range/alignment checks and
// the IF/ID register. Macro BRANCH_DELAY_SLOT_EN keeps the delay-slot word.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] F_instr,
    output logic [31:0] F_pc,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic        D_valid,
    output logic        D_exc
);

    logic [31:0] pc_q, pc_d;
    logic        misalign_q, misalign_d;
    logic        out_of_range;
    logic        fetch_exc;
    logic        flush;
    if_id_t      fetch_word;
    if_id_t      d_word;

    // Word index compared at 32 bits so any IM_WORDS value is well defined.
    assign out_of_range = ({2'b00, pc_q[31:2]} >= IM_WORDS);
    assign fetch_exc    = out_of_range | misalign_q;

    always_comb begin
        pc_d       = pc_q;
        misalign_d = misalign_q;
        if (!stall) begin
            if (redirect) begin
                pc_d       = {redirect_pc[31:2], 2'b00};
                misalign_d = (redirect_pc[1:0] != 2'b00);
            end else begin
                pc_d       = pc_q + 32'd4;
                misalign_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        fetch_word.instr = fetch_exc ? NOP_INSTR : F_instr;
        fetch_word.pc    = pc_q;
        fetch_word.valid = 1'b1;
        fetch_word.exc   = fetch_exc;
    end

`ifdef BRANCH_DELAY_SLOT_EN
    assign flush = 1'b0;
`else
    assign flush = redirect;
`endif

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .flush (flush),
        .d     (fetch_word),
        .q     (d_word)
    );

    assign F_pc    = pc_q;
    assign D_instr = d_word.instr;
    assign D_pc    = d_word.pc;
    assign D_valid = d_word.valid;
    assign D_exc   = d_word.exc;

endmodule
